window_3x3_linebuf: RTL and testbench

- Streaming 3x3 neighbourhood generator. Turns a raster-order 8-bit grayscale pixel stream into the nine-tap window s0..s8 consumed by the Sobel gradient and median-denoise stages.
- Sits between the pixel source (camera/frame-read path) and the combinational window processors.
- Holds two previous lines in line buffers plus a 3x3 register window.
- Emits only fully interior windows, tagged with centre coordinates so downstream can zero-fill border pixels.

---
 rtl/window_3x3_linebuf_pkg.sv | 13 +
 rtl/window_3x3_linebuf_line_buffer_ram.sv | 22 ++
 rtl/window_3x3_linebuf.sv | 142 ++++++++++++++
 tb/tb_window_3x3_linebuf.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/window_3x3_linebuf_pkg.sv
// Shared image-processing types: pixel width, default frame size and the
// nine-tap window handed to the Sobel and median stages.
package window_3x3_linebuf_pkg;
  localparam int PIX_W         = 8;
  localparam int IMG_W_DEFAULT = 640;
  localparam int IMG_H_DEFAULT = 480;

  typedef logic [PIX_W-1:0] pixel_t;
  // Index is the tap number: [0]=s0 (top-left) .. [8]=s8 (bottom-right).
  typedef logic [8:0][PIX_W-1:0] window_t;
  // One window column: [0]=row y-2, [1]=row y-1, [2]=row y.
  typedef logic [2:0][PIX_W-1:0] column_t;
endpackage

// File: rtl/window_3x3_linebuf_line_buffer_ram.sv
// Simple dual-port RAM with registered read. A read and a write to the same
// address in one cycle return the old contents.
module line_buffer_ram #(
  parameter int DEPTH = 640,
  parameter int WIDTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
    if (wr_en) mem[wr_addr] <= wr_data;
  end
endmodule

// File: rtl/window_3x3_linebuf.sv
// Raster pixel stream to 3x3 window generator. Two line buffers supply rows
// y-1 and y-2; only fully interior windows are emitted, 2 clk after their pixel.
module window_3x3_linebuf
  import window_3x3_linebuf_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEFAULT,
  parameter int IMG_H = IMG_H_DEFAULT,
  parameter int XW    = $clog2(IMG_W),
  parameter int YW    = $clog2(IMG_H)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_sof,
  input  logic [PIX_W-1:0] in_pixel,
  output logic             win_valid,
  output logic [PIX_W-1:0] s0,
  output logic [PIX_W-1:0] s1,
  output logic [PIX_W-1:0] s2,
  output logic [PIX_W-1:0] s3,
  output logic [PIX_W-1:0] s4,
  output logic [PIX_W-1:0] s5,
  output logic [PIX_W-1:0] s6,
  output logic [PIX_W-1:0] s7,
  output logic [PIX_W-1:0] s8,
  output logic [XW-1:0]    cx,
  output logic [YW-1:0]    cy,
  output logic             frame_done
);
  logic [XW-1:0] x_cnt, acc_x, s1_x;
  logic [YW-1:0] y_cnt, acc_y, s1_y;
  logic          s1_valid;
  pixel_t        s1_pix, lb1_q, lb2_q;
  column_t       col_l, col_c, new_col;
  window_t       next_win, win_q;
  logic          emit, last_pos;

  // A start-of-frame pixel is placed at (0,0) regardless of counter state.
  assign acc_x = in_sof ? '0 : x_cnt;
  assign acc_y = in_sof ? '0 : y_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_cnt <= '0;
      y_cnt <= '0;
    end else if (in_valid) begin
      if (acc_x == XW'(IMG_W-1)) begin
        x_cnt <= '0;
        y_cnt <= (acc_y == YW'(IMG_H-1)) ? '0 : acc_y + YW'(1);
      end else begin
        x_cnt <= acc_x + XW'(1);
        y_cnt <= acc_y;
      end
    end
  end

  // LB1 holds row y-1; LB2 is refilled one cycle later from LB1's old word.
  line_buffer_ram #(.DEPTH(IMG_W), .WIDTH(PIX_W), .AW(XW)) u_lb1 (
    .clk    (clk),
    .wr_en  (in_valid),
    .wr_addr(acc_x),
    .wr_data(in_pixel),
    .rd_en  (in_valid),
    .rd_addr(acc_x),
    .rd_data(lb1_q)
  );

  line_buffer_ram #(.DEPTH(IMG_W), .WIDTH(PIX_W), .AW(XW)) u_lb2 (
    .clk    (clk),
    .wr_en  (s1_valid),
    .wr_addr(s1_x),
    .wr_data(lb1_q),
    .rd_en  (in_valid),
    .rd_addr(acc_x),
    .rd_data(lb2_q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_pix   <= '0;
      s1_x     <= '0;
      s1_y     <= '0;
    end else begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_pix <= in_pixel;
        s1_x   <= acc_x;
        s1_y   <= acc_y;
      end
    end
  end

  assign new_col  = {s1_pix, lb1_q, lb2_q};
  assign emit     = s1_valid && (s1_x >= XW'(2)) && (s1_y >= YW'(2));
  assign last_pos = (s1_x == XW'(IMG_W-1)) && (s1_y == YW'(IMG_H-1));

  // The right column of the output window comes straight from stage 1,
  // so only two columns need to be held between pixels.
  always_comb begin
    next_win = '0;
    for (int r = 0; r < 3; r++) begin
      next_win[3*r]   = col_l[r];
      next_win[3*r+1] = col_c[r];
      next_win[3*r+2] = new_col[r];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_l      <= '0;
      col_c      <= '0;
      win_q      <= '0;
      cx         <= '0;
      cy         <= '0;
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      win_valid  <= emit;
      frame_done <= emit && last_pos;
      if (s1_valid) begin
        col_l <= col_c;
        col_c <= new_col;
      end
      if (emit) begin
        win_q <= next_win;
        cx    <= s1_x - XW'(1);
        cy    <= s1_y - YW'(1);
      end
    end
  end

  assign s0 = win_q[0];
  assign s1 = win_q[1];
  assign s2 = win_q[2];
  assign s3 = win_q[3];
  assign s4 = win_q[4];
  assign s5 = win_q[5];
  assign s6 = win_q[6];
  assign s7 = win_q[7];
  assign s8 = win_q[8];
endmodule

// File: tb/tb_window_3x3_linebuf.sv
// Bench for window_3x3_linebuf on an 8x6 frame: a 2-D frame model predicts every
// window and its arrival cycle; a table drives whole-frame runs.
module tb_window_3x3_linebuf;
  localparam int W = 8;
  localparam int H = 6;

  typedef struct packed {
    logic [31:0] due;
    logic        fd;
    logic [2:0]  cx;
    logic [2:0]  cy;
    logic [71:0] taps;
  } exp_t;
  localparam int EW = $bits(exp_t);

  typedef struct {
    string name;
    int    gap_pct;
    int    step;
    int    frames;
    int    exp_win;
    int    exp_fd;
    int    chk_first;
    int    pick_idx;
    int    pick_cx;
    int    pick_cy;
    int    pick_s0;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_sof = 1'b0;
  logic [7:0] in_pixel = 8'd0;
  logic       win_valid, frame_done;
  logic [7:0] s0, s1, s2, s3, s4, s5, s6, s7, s8;
  logic [2:0] cx, cy;

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  window_3x3_linebuf #(.IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .in_pixel(in_pixel),
    .win_valid(win_valid),
    .s0(s0), .s1(s1), .s2(s2), .s3(s3), .s4(s4), .s5(s5), .s6(s6), .s7(s7), .s8(s8),
    .cx(cx), .cy(cy), .frame_done(frame_done)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  int total = 0;
  int bad = 0;
  int win_cnt, fd_cnt, cx_oor, pick_idx;
  logic        got_first;
  logic [71:0] first_taps;
  logic [2:0]  first_cx, first_cy, fd_cx, fd_cy, pick_cx, pick_cy;
  logic [7:0]  fd_s8, pick_s0;

  // frame model
  logic [7:0] img [H][W];
  int mx = 0;
  int my = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic clear_stats(input int pick);
    win_cnt = 0; fd_cnt = 0; cx_oor = 0; got_first = 1'b0; pick_idx = pick;
    pick_cx = '0; pick_cy = '0; pick_s0 = '0;
  endtask

  always @(negedge clk) begin
    exp_t act, e;
    if (!rst) begin
      if (frame_done && !win_valid) begin
        total++; bad++;
        $display("FAIL frame_done_without_win_valid at cycle %0d", cyc);
      end
      if (win_valid) begin
        act.due  = cyc;
        act.fd   = frame_done;
        act.cx   = cx;
        act.cy   = cy;
        act.taps = {s0, s1, s2, s3, s4, s5, s6, s7, s8};
        if (!got_first) begin
          got_first = 1'b1; first_taps = act.taps; first_cx = cx; first_cy = cy;
        end
        if (win_cnt == pick_idx) begin
          pick_cx = cx; pick_cy = cy; pick_s0 = s0;
        end
        if (frame_done) begin
          fd_cnt++; fd_cx = cx; fd_cy = cy; fd_s8 = s8;
        end
        if (cx < 3'd1 || cx > 3'd6) cx_oor++;
        win_cnt++;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_window cycle=%0d cx=%0d cy=%0d taps=%h", cyc, cx, cy, act.taps);
        end else begin
          e = exp_t'(exp_q.pop_front());
          if (act !== e) begin
            bad++;
            $display("FAIL window got due=%0d fd=%0b cx=%0d cy=%0d taps=%h exp due=%0d fd=%0b cx=%0d cy=%0d taps=%h",
                     act.due, act.fd, act.cx, act.cy, act.taps, e.due, e.fd, e.cx, e.cy, e.taps);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v, input logic sof, input logic [7:0] pix);
    exp_t e;
    @(posedge clk); #1;
    in_valid = v; in_sof = sof; in_pixel = pix;
    if (v) begin
      if (sof) begin mx = 0; my = 0; end
      img[my][mx] = pix;
      if (mx >= 2 && my >= 2) begin
        e.due  = cyc + 2;
        e.fd   = (mx == W-1) && (my == H-1);
        e.cx   = 3'(mx-1);
        e.cy   = 3'(my-1);
        e.taps = {img[my-2][mx-2], img[my-2][mx-1], img[my-2][mx],
                  img[my-1][mx-2], img[my-1][mx-1], img[my-1][mx],
                  img[my][mx-2],   img[my][mx-1],   img[my][mx]};
        exp_q.push_back(EW'(e));
      end
      if (mx == W-1) begin
        mx = 0;
        my = (my == H-1) ? 0 : my + 1;
      end else begin
        mx++;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
  endtask

  task automatic run_frames(input int gap_pct, input int step, input int frames);
    for (int f = 0; f < frames; f++)
      for (int y = 0; y < H; y++)
        for (int x = 0; x < W; x++) begin
          for (int g = 0; g < 3 && int'($urandom_range(0, 99)) < gap_pct; g++) idle(1);
          drive(1'b1, (x == 0 && y == 0), 8'(8*y + x + f*step));
        end
  endtask

  task automatic drain(input string name);
    idle(4);
    check({name, "_drained"}, 128'(exp_q.size()), 128'd0);
  endtask

  task automatic check_ramp_ends(input string name);
    check({name, "_first_taps"}, 128'(first_taps), 128'(72'h000102_08090a_101112));
    check({name, "_first_centre"}, {first_cx, first_cy}, {3'd1, 3'd1});
    check({name, "_fd_window"}, {fd_cx, fd_cy, fd_s8}, {3'd6, 3'd4, 8'd47});
  endtask

  // ---------------- test ----------------
  vec_t vecs[3];

  initial begin
    vecs[0] = '{"ramp_cont",  0,   0, 1, 24, 1, 1, 23, 6, 4, 29};
    vecs[1] = '{"ramp_gaps",  50,  0, 1, 24, 1, 1, 5,  6, 1, 5};
    vecs[2] = '{"two_frames", 0, 100, 2, 48, 2, 0, 24, 1, 1, 100};
    clear_stats(-1);

    repeat (3) @(posedge clk);
    #1;
    check("reset_state", {win_valid, frame_done, cx, cy, s0, s1, s2, s3, s4, s5, s6, s7, s8}, '0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("after_release", {win_valid, frame_done, cx, cy}, '0);

    for (int i = 0; i < 3; i++) begin
      clear_stats(vecs[i].pick_idx);
      run_frames(vecs[i].gap_pct, vecs[i].step, vecs[i].frames);
      drain(vecs[i].name);
      check({vecs[i].name, "_win_count"}, 128'(win_cnt), 128'(vecs[i].exp_win));
      check({vecs[i].name, "_fd_count"}, 128'(fd_cnt), 128'(vecs[i].exp_fd));
      check({vecs[i].name, "_pick"}, {pick_cx, pick_cy, pick_s0},
            {3'(vecs[i].pick_cx), 3'(vecs[i].pick_cy), 8'(vecs[i].pick_s0)});
      if (vecs[i].chk_first != 0) check_ramp_ends(vecs[i].name);
    end

    // in_sof at (3,3): 6 row-2 windows plus (2,3) of the old frame, then new frame
    clear_stats(7);
    for (int y = 0; y < 4; y++)
      for (int x = 0; x < W; x++)
        if (!(y == 3 && x >= 3)) drive(1'b1, (x == 0 && y == 0), 8'(8*y + x));
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        drive(1'b1, (x == 0 && y == 0), 8'(8*y + x + 50));
    drain("mid_sof");
    check("mid_sof_win_count", 128'(win_cnt), 128'd31);
    check("mid_sof_fd_count", 128'(fd_cnt), 128'd1);
    check("mid_sof_first_new", {pick_cx, pick_cy, pick_s0}, {3'd1, 3'd1, 8'd50});

    // asynchronous reset during row 3
    clear_stats(-1);
    for (int y = 0; y < 4; y++)
      for (int x = 0; x < W; x++)
        if (!(y == 3 && x >= 5)) drive(1'b1, (x == 0 && y == 0), 8'(8*y + x));
    @(posedge clk); #1;
    in_valid = 1'b0; in_sof = 1'b0;
    check("pre_reset_win_valid", 128'(win_valid), 128'd1);
    #2 rst = 1'b1;
    #1;
    check("async_reset_outputs", {win_valid, frame_done, cx, cy, s0, s1, s2, s3, s4, s5, s6, s7, s8}, '0);
    exp_q.delete();
    mx = 0; my = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    clear_stats(-1);
    run_frames(0, 0, 1);
    drain("post_reset");
    check("post_reset_win_count", 128'(win_cnt), 128'd24);
    check("post_reset_fd_count", 128'(fd_cnt), 128'd1);
    check_ramp_ends("post_reset");

    // line wrap: bright columns 0 and 1 must never appear on the right of a window
    clear_stats(-1);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        drive(1'b1, (x == 0 && y == 0), (x < 2) ? 8'd255 : 8'd0);
    drain("line_wrap");
    check("line_wrap_win_count", 128'(win_cnt), 128'd24);
    check("line_wrap_cx_range", 128'(cx_oor), 128'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
